grf_wb_arbiter: RTL and testbench

//  Write-side front end of the general register file. It merges the pipeline W-stage writeback

---
 rtl/grf_wb_arbiter_pkg.sv | 31 +++
 rtl/grf_wb_arbiter_wb_queue.sv | 112 +++++++++++
 rtl/grf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter_pkg
//   Shared width macros and types for the GRF write-side front end.
//   Macros:  `REG_ZERO  register $0 encoding
//            `REG_W     register number width
//            `DATA_W    register data width
//   Package: reg_num_t / reg_data_t scalar types and grf_wr_t, the bundle
//            that is driven onto the GRF write port.
// ---------------------------------------------------------------------------
`ifndef GRF_WB_ARBITER_MACROS
`define GRF_WB_ARBITER_MACROS
`define REG_ZERO 5'd0
`define REG_W 5
`define DATA_W 32
`endif

package grf_wb_arbiter_pkg;

  typedef logic [`REG_W-1:0]  reg_num_t;
  typedef logic [`DATA_W-1:0] reg_data_t;

  // One GRF write-port transaction.
  typedef struct packed {
    logic      we;
    reg_num_t  wn;
    reg_data_t wd;
  } grf_wr_t;

  localparam grf_wr_t GRF_WR_IDLE = '{we: 1'b0, wn: `REG_ZERO, wd: 32'd0};

endpackage

// File: rtl/grf_wb_arbiter_wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
//   In-order circular buffer holding late MDU results until the GRF write
//   port is free. Each slot carries a valid bit so a pending write can be
//   cancelled in place (leaving a hole that still occupies its slot).
//   Ports:
//     clk, reset_n                clock, async active-low reset
//     push_i, push_num_i/data_i   write a new entry at the tail
//     pop_i                       retire the head slot (valid or hole)
//     kill_en_i, kill_num_i       invalidate every valid entry with that num
//     head_valid/num/data_o       head slot contents
//     full_o, empty_o, count_o    occupancy (holes included)
//     ent_valid_o, ent_num_o      per-slot valid/num for hazard matching
//   The parent must never push when full or pop when empty.
// ---------------------------------------------------------------------------
module wb_queue
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  reg_num_t                     push_num_i,
  input  reg_data_t                    push_data_i,
  input  logic                         pop_i,
  input  logic                         kill_en_i,
  input  reg_num_t                     kill_num_i,
  output logic                         head_valid_o,
  output reg_num_t                     head_num_o,
  output reg_data_t                    head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [AW:0]                  count_o,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][`REG_W-1:0] ent_num_o
);

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][`REG_W-1:0]  num_q;
  logic [DEPTH-1:0][`DATA_W-1:0] data_q;
  logic [AW-1:0]                 head_q, head_d;
  logic [AW-1:0]                 tail_q, tail_d;
  logic [AW:0]                   count_q, count_d;

  // Next-state for valid bits, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Cancel older writes to a register that the W stage just wrote.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en_i && valid_q[i] && (num_q[i] == kill_num_i)) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_d[i];
      end
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    // The tail slot is always free when a push is allowed, so no conflict
    // with the kill/pop updates above.
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Slot storage and pointers; reset discards everything queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      num_q   <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) begin
        num_q[tail_q]  <= push_num_i;
        data_q[tail_q] <= push_data_i;
      end
    end
  end

  assign head_valid_o = valid_q[head_q];
  assign head_num_o   = num_q[head_q];
  assign head_data_o  = data_q[head_q];
  assign full_o       = (count_q == (AW+1)'(DEPTH));
  assign empty_o      = (count_q == (AW+1)'(0));
  assign count_o      = count_q;
  assign ent_valid_o  = valid_q;
  assign ent_num_o    = num_q;

endmodule

// File: rtl/grf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter
//   Merges W-stage writeback with late MDU results onto the single GRF write
//   port. W writes always win; MDU results wait in wb_queue and drain when
//   the port is idle. Also reports registers with pending MDU writes so the
//   D stage can stall on RAW/WAW hazards.
//   Ports:
//     clk, reset_n               clock, async active-low reset
//     wb_en/wb_num/wb_data       W-stage write (never back-pressured)
//     mdu_valid/num/data, mdu_ready   MDU result handshake
//     grf_we/grf_wn/grf_wd       GRF write port
//     q_num1..3 / q_busy1..3     D-stage busy queries
//     pend_cnt                   queue occupancy (holes included)
// ---------------------------------------------------------------------------
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wb_en,
  input  logic [`REG_W-1:0]  wb_num,
  input  logic [`DATA_W-1:0] wb_data,
  input  logic               mdu_valid,
  output logic               mdu_ready,
  input  logic [`REG_W-1:0]  mdu_num,
  input  logic [`DATA_W-1:0] mdu_data,
  output logic               grf_we,
  output logic [`REG_W-1:0]  grf_wn,
  output logic [`DATA_W-1:0] grf_wd,
  input  logic [`REG_W-1:0]  q_num1,
  input  logic [`REG_W-1:0]  q_num2,
  input  logic [`REG_W-1:0]  q_num3,
  output logic               q_busy1,
  output logic               q_busy2,
  output logic               q_busy3,
  output logic [AW:0]        pend_cnt
);

  logic                         wb_fire_s;
  logic                         push_s;
  logic                         push_store_s;
  logic                         pop_s;
  logic                         head_valid_s;
  reg_num_t                     head_num_s;
  reg_data_t                    head_data_s;
  logic                         full_s;
  logic                         empty_s;
  logic [DEPTH-1:0]             ent_valid_s;
  logic [DEPTH-1:0][`REG_W-1:0] ent_num_s;
  grf_wr_t                      grf_s;

  // True when q names a register with a queued write or the write being
  // accepted this cycle. $0 is never busy.
  function automatic logic reg_busy(
    input reg_num_t                     q,
    input logic [DEPTH-1:0]             v,
    input logic [DEPTH-1:0][`REG_W-1:0] n,
    input logic                         push_en,
    input reg_num_t                     push_num
  );
    logic hit;
    hit = push_en && (push_num == q);
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (v[i] && (n[i] == q));
    end
    return (q != `REG_ZERO) && hit;
  endfunction

  // Readiness uses registered occupancy only: no credit for a same-cycle pop.
  assign mdu_ready    = reset_n && !full_s;
  assign wb_fire_s    = wb_en && (wb_num != `REG_ZERO);
  assign push_s       = mdu_valid && mdu_ready;
  // Results for $0 are acknowledged but never stored.
  assign push_store_s = push_s && (mdu_num != `REG_ZERO);
  // The head retires (write or silent hole) whenever the W stage leaves the
  // port free.
  assign pop_s        = !empty_s && !wb_fire_s;

  wb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_queue (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push_store_s),
    .push_num_i   (mdu_num),
    .push_data_i  (mdu_data),
    .pop_i        (pop_s),
    .kill_en_i    (wb_fire_s),
    .kill_num_i   (wb_num),
    .head_valid_o (head_valid_s),
    .head_num_o   (head_num_s),
    .head_data_o  (head_data_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .count_o      (pend_cnt),
    .ent_valid_o  (ent_valid_s),
    .ent_num_o    (ent_num_s)
  );

  // Write-port priority mux: W stage first, then a live queue head.
  always_comb begin
    grf_s = GRF_WR_IDLE;
    if (!reset_n) begin
      grf_s = GRF_WR_IDLE;
    end else if (wb_fire_s) begin
      grf_s = '{we: 1'b1, wn: wb_num, wd: wb_data};
    end else if (!empty_s && head_valid_s) begin
      grf_s = '{we: 1'b1, wn: head_num_s, wd: head_data_s};
    end else begin
      grf_s = GRF_WR_IDLE;
    end
  end

  assign grf_we = grf_s.we;
  assign grf_wn = grf_s.wn;
  assign grf_wd = grf_s.wd;

  // Push term is already suppressed in reset via mdu_ready.
  assign q_busy1 = reg_busy(q_num1, ent_valid_s, ent_num_s, push_store_s, mdu_num);
  assign q_busy2 = reg_busy(q_num2, ent_valid_s, ent_num_s, push_store_s, mdu_num);
  assign q_busy3 = reg_busy(q_num3, ent_valid_s, ent_num_s, push_store_s, mdu_num);

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_num = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_num = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        grf_we;
  logic [4:0]  grf_wn;
  logic [31:0] grf_wd;
  logic [4:0]  q_num1 = 5'd0, q_num2 = 5'd0, q_num3 = 5'd0;
  logic        q_busy1, q_busy2, q_busy3;
  logic [AW:0] pend_cnt;

  int checks = 0;
  int errors = 0;

  grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_num(mdu_num), .mdu_data(mdu_data),
    .grf_we(grf_we), .grf_wn(grf_wn), .grf_wd(grf_wd),
    .q_num1(q_num1), .q_num2(q_num2), .q_num3(q_num3),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .q_busy3(q_busy3),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of pending MDU writes; cancelled ones stay
  // in place as dead slots until they reach the front.
  typedef struct {
    logic [4:0]  num;
    logic [31:0] data;
    bit          alive;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        ready;
    logic [2:0]  busy;
    logic [AW:0] pend;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic bit model_busy(input logic [4:0] q, input bit acc, input logic [4:0] mn);
    if (q == 5'd0) return 1'b0;
    if (acc && mn == q) return 1'b1;
    foreach (mq[i]) if (mq[i].alive && mq[i].num == q) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle (called at posedge+1), queue the expectation, then
  // advance the model across the next edge.
  task automatic cycle(input bit we, input logic [4:0] wn, input logic [31:0] wd,
                       input bit mv, input logic [4:0] mn, input logic [31:0] md,
                       input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3);
    exp_t e;
    bit   fire, acc;
    wb_en = we; wb_num = wn; wb_data = wd;
    mdu_valid = mv; mdu_num = mn; mdu_data = md;
    q_num1 = q1; q_num2 = q2; q_num3 = q3;
    fire = we && (wn != 5'd0);
    e.ready = (mq.size() < DEPTH);
    acc = mv && e.ready && (mn != 5'd0);
    if (fire) begin
      e.we = 1'b1; e.wn = wn; e.wd = wd;
    end else if (mq.size() > 0 && mq[0].alive) begin
      e.we = 1'b1; e.wn = mq[0].num; e.wd = mq[0].data;
    end else begin
      e.we = 1'b0; e.wn = 5'd0; e.wd = 32'd0;
    end
    e.busy = {model_busy(q3, acc, mn), model_busy(q2, acc, mn), model_busy(q1, acc, mn)};
    e.pend = (AW+1)'(mq.size());
    exp_q.push_back(e);
    @(posedge clk);
    if (fire) begin
      foreach (mq[i]) if (mq[i].num == wn) mq[i].alive = 1'b0;
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
    end
    if (acc) mq.push_back('{num: mn, data: md, alive: 1'b1});
    #1;
  endtask

  task automatic idle(input logic [4:0] q1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0, 5'd0);
  endtask

  // Monitor: compares every presented cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grf_we", 32'(grf_we), 32'(e.we));
        chk("grf_wn", 32'(grf_wn), 32'(e.wn));
        chk("grf_wd", grf_wd, e.wd);
        chk("mdu_ready", 32'(mdu_ready), 32'(e.ready));
        chk("q_busy", 32'({q_busy3, q_busy2, q_busy1}), 32'(e.busy));
        chk("pend_cnt", 32'(pend_cnt), 32'(e.pend));
      end
    end
  end

  initial begin
    // 1: reset state, then idle after release
    #3;
    chk("rst_grf_we", 32'(grf_we), 32'd0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
    chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_q_busy", 32'({q_busy3, q_busy2, q_busy1}), 32'd0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(5'd8);

    // 2: single MDU result drains next cycle
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234, 5'd8, 5'd0, 5'd0);
    idle(5'd8);
    idle(5'd8);

    // 3: W stage owns the port for 3 cycles, queue fills, then drains in order
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'd1, 5'd8, 5'd9, 5'd4);
    cycle(1'b1, 5'd4, 32'h45, 1'b1, 5'd9, 32'd2, 5'd8, 5'd9, 5'd4);
    cycle(1'b1, 5'd4, 32'h46, 1'b1, 5'd10, 32'd3, 5'd8, 5'd9, 5'd10);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9, 5'd0);
    idle(5'd0);

    // 4: newer W write to r5 cancels the queued r5 write
    cycle(1'b1, 5'd4, 32'h1, 1'b1, 5'd5, 32'hAA, 5'd5, 5'd0, 5'd0);
    cycle(1'b1, 5'd5, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
    idle(5'd5);
    idle(5'd5);

    // 5: W write to $0 leaves the port to the queue; MDU push to $0 discarded
    cycle(1'b1, 5'd4, 32'h2, 1'b1, 5'd7, 32'd3, 5'd7, 5'd0, 5'd0);
    cycle(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77, 5'd7, 5'd0, 5'd0);
    idle(5'd0);

    // 6: busy query, then asynchronous reset mid-drain
    cycle(1'b1, 5'd4, 32'h3, 1'b1, 5'd8, 32'h88, 5'd8, 5'd0, 5'd0);
    cycle(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd0);
    wb_en = 1'b0; wb_num = 5'd0; mdu_valid = 1'b0; q_num1 = 5'd8;
    @(negedge clk);
    chk("pre_rst_busy1", 32'(q_busy1), 32'd1);
    chk("pre_rst_grf_wn", 32'(grf_wn), 32'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("midrst_busy1", 32'(q_busy1), 32'd0);
    chk("midrst_grf_we", 32'(grf_we), 32'd0);
    chk("midrst_mdu_ready", 32'(mdu_ready), 32'd0);
    mq.delete();
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(5'd8);
    idle(5'd8);

    // Randomized traffic over a small register set to provoke matches
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 6)), $urandom,
            ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 6)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 4; n++) idle(5'd0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
